// File: rtl/debug_pkg.sv
// Shared constants and helpers for the front-panel debug-state selector.
// Debounce lengths cover simulation and the real board's switch bounce.
package debug_pkg;

  localparam int DEBOUNCE_SIM   = 4;
  localparam int DEBOUNCE_BOARD = 500000;

  // Ceiling log2 for parameter arithmetic. clog2(1) is 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One front-panel button: two-flop synchroniser, stable-sample debouncer,
// and a single-cycle pulse on each accepted press.
module btn_debounce
  import debug_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int                CNT_W    = clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             db_q, db_d;
  logic             db_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any sample that matches the current level restarts the count, so only an
  // unbroken run of DEBOUNCE_CYCLES opposite samples flips the level.
  always_comb begin
    // NOTE: defaults come first so every path assigns every output; no latch.
    db_d  = db_q;
    cnt_d = '0;
    if (s2_q != db_q) begin
      if (cnt_q == CNT_LAST) db_d = s2_q;
      else                   cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s1_q      <= btn_raw;
      s2_q      <= s1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      cnt_q     <= cnt_d;
    end
  end

  assign level = db_q;
  assign rise  = db_q & ~db_prev_q;

endmodule

// File: rtl/debug_state_sel.sv
// Debug-view selector: clean next/prev presses step a state index that picks
// which internal view is muxed onto the LEDs / 7-segment display.
module debug_state_sel
  import debug_pkg::*;
#(
  parameter int  NUM_STATES      = 4,
  localparam int STATE_W         = clog2(NUM_STATES),
  parameter int  DEBOUNCE_CYCLES = DEBOUNCE_SIM,
  parameter bit  WRAP            = 1'b1,
  parameter int  RESET_STATE     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_next,
  input  logic               btn_prev,
  output logic [STATE_W-1:0] d_state,
  output logic               changed
);

  localparam logic [STATE_W-1:0] LAST_STATE = STATE_W'(NUM_STATES - 1);
  localparam logic [STATE_W-1:0] INIT_STATE = STATE_W'(RESET_STATE);

  logic               next_rise, prev_rise;
  logic               unused_next_level, unused_prev_level;
  logic               out_of_range;
  logic [STATE_W-1:0] d_state_q, d_state_d;
  logic               changed_q, changed_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_next),
    .level  (unused_next_level),
    .rise   (next_rise)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_prev),
    .level  (unused_prev_level),
    .rise   (prev_rise)
  );

  // Codes above LAST_STATE exist only when NUM_STATES is not a power of two.
  if (NUM_STATES == (1 << STATE_W)) begin : g_full_range
    assign out_of_range = 1'b0;
  end else begin : g_partial_range
    assign out_of_range = (d_state_q > LAST_STATE);
  end

  always_comb begin
    d_state_d = d_state_q;
    if (out_of_range) begin
      d_state_d = INIT_STATE;
    end else if (next_rise && !prev_rise) begin
      if (d_state_q != LAST_STATE) d_state_d = d_state_q + STATE_W'(1);
      else if (WRAP)               d_state_d = '0;
    end else if (prev_rise && !next_rise) begin
      if (d_state_q != '0) d_state_d = d_state_q - STATE_W'(1);
      else if (WRAP)       d_state_d = LAST_STATE;
    end
    // A saturated hold or a cancelled double press leaves the strobe low.
    changed_d = (d_state_d != d_state_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_state_q <= INIT_STATE;
      changed_q <= 1'b0;
    end else begin
      d_state_q <= d_state_d;
      changed_q <= changed_d;
    end
  end

  assign d_state = d_state_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_debug_state_sel.sv
// Bench for debug_state_sel: a wrapping and a saturating instance share the
// same buttons and are compared every cycle against a window-based model.
module tb_debug_state_sel;

  localparam int N  = 5;
  localparam int D  = 4;
  localparam int RS = 0;
  localparam int SW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          btn_next = 1'b0;
  logic          btn_prev = 1'b0;
  logic [SW-1:0] d_state_w, d_state_s;
  logic          changed_w, changed_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  debug_state_sel #(
    .NUM_STATES(N), .DEBOUNCE_CYCLES(D), .WRAP(1'b1), .RESET_STATE(RS)
  ) dut_w (
    .clk(clk), .rst(rst), .btn_next(btn_next), .btn_prev(btn_prev),
    .d_state(d_state_w), .changed(changed_w)
  );

  debug_state_sel #(
    .NUM_STATES(N), .DEBOUNCE_CYCLES(D), .WRAP(1'b0), .RESET_STATE(RS)
  ) dut_s (
    .clk(clk), .rst(rst), .btn_next(btn_next), .btn_prev(btn_prev),
    .d_state(d_state_s), .changed(changed_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Raw history per button, bit 0 = newest raw sample. The level a button
  // settles to is decided by the raw samples 2..D+1 edges old (the
  // synchroniser delay): if all D of them oppose the current level, it flips.
  bit [D:0] hist_n, hist_p;
  bit       db_n, db_p, dbq_n, dbq_p;
  int       m_w, m_s;
  bit       mc_w, mc_s;
  bit       model_live = 1'b0;

  function automatic bit settle(input bit [D:0] h, input bit db);
    if (h[D:1] == {D{~db}}) return ~db;
    return db;
  endfunction

  function automatic int step(input int s, input bit up, input bit wrap);
    int t;
    if (s >= N) return RS;
    t = up ? s + 1 : s - 1;
    if (wrap) return (t + N) % N;
    if (t < 0) return 0;
    if (t > N - 1) return N - 1;
    return t;
  endfunction

  always @(posedge clk) begin
    bit pn, pp;
    int nw, ns;
    model_live = 1'b1;
    if (rst) begin
      hist_n = '0; hist_p = '0;
      db_n = 0; db_p = 0; dbq_n = 0; dbq_p = 0;
      m_w = RS; m_s = RS; mc_w = 0; mc_s = 0;
    end else begin
      pn = db_n && !dbq_n;
      pp = db_p && !dbq_p;
      nw = m_w;
      ns = m_s;
      if (pn != pp) begin
        nw = step(m_w, pn, 1'b1);
        ns = step(m_s, pn, 1'b0);
      end
      mc_w = (nw != m_w);
      mc_s = (ns != m_s);
      m_w  = nw;
      m_s  = ns;
      dbq_n = db_n;
      dbq_p = db_p;
      db_n  = settle(hist_n, db_n);
      db_p  = settle(hist_p, db_p);
      hist_n = {hist_n[D-1:0], btn_next};
      hist_p = {hist_p[D-1:0], btn_prev};
    end
  end

  int pulses_w = 0;
  int pulses_s = 0;

  always @(negedge clk) begin
    if (model_live) begin
      check("model d_state wrap", 32'(d_state_w), 32'(m_w));
      check("model changed wrap", 32'(changed_w), 32'(mc_w));
      check("model d_state sat",  32'(d_state_s), 32'(m_s));
      check("model changed sat",  32'(changed_s), 32'(mc_s));
      if (changed_w === 1'b1) pulses_w++;
      if (changed_s === 1'b1) pulses_s++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    cycles(n);
    rst = 1'b0;
  endtask

  task automatic press(input bit nx, input bit pv, input int hi, input int lo);
    btn_next = nx;
    btn_prev = pv;
    cycles(hi);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    cycles(lo);
  endtask

  initial begin
    int base_w, base_s;
    int exp_seq [5] = '{1, 2, 3, 4, 0};
    bit bounce  [7] = '{1, 1, 0, 1, 1, 1, 0};

    // 1: reset values, latency, no auto-repeat while held
    do_reset(2);
    check("reset d_state", 32'(d_state_w), 32'(RS));
    check("reset changed", 32'(changed_w), 32'd0);
    base_w   = pulses_w;
    btn_next = 1'b1;
    cycles(6);
    check("edge6 d_state", 32'(d_state_w), 32'd0);
    cycles(1);
    check("edge7 d_state", 32'(d_state_w), 32'd1);
    check("edge7 changed", 32'(changed_w), 32'd1);
    cycles(14);
    check("held pulses", 32'(pulses_w - base_w), 32'd1);
    check("held d_state", 32'(d_state_w), 32'd1);
    btn_next = 1'b0;
    cycles(10);

    // 2: five clean next presses wrap around; saturating copy stops at 4
    do_reset(2);
    base_w = pulses_w;
    base_s = pulses_s;
    for (int i = 0; i < 5; i++) begin
      press(1'b1, 1'b0, 10, 10);
      check("next seq", 32'(d_state_w), 32'(exp_seq[i]));
    end
    check("next pulses wrap", 32'(pulses_w - base_w), 32'd5);
    check("next sat top", 32'(d_state_s), 32'(N - 1));
    check("next pulses sat", 32'(pulses_s - base_s), 32'd4);

    // 3: prev from 0 wraps to top; saturating copy holds with no strobe
    do_reset(2);
    base_s = pulses_s;
    press(1'b0, 1'b1, 10, 10);
    check("prev wrap", 32'(d_state_w), 32'(N - 1));
    check("prev sat", 32'(d_state_s), 32'd0);
    check("prev sat pulses", 32'(pulses_s - base_s), 32'd0);

    // 4: bounce then steady high gives exactly one step
    do_reset(2);
    base_w = pulses_w;
    for (int i = 0; i < 7; i++) begin
      btn_next = bounce[i];
      cycles(1);
    end
    btn_next = 1'b1;
    cycles(20);
    btn_next = 1'b0;
    cycles(10);
    check("bounce pulses", 32'(pulses_w - base_w), 32'd1);
    check("bounce d_state", 32'(d_state_w), 32'd1);

    // 5: simultaneous presses cancel; staggered presses both count
    do_reset(2);
    base_w = pulses_w;
    press(1'b1, 1'b1, 10, 10);
    check("simul d_state", 32'(d_state_w), 32'd0);
    check("simul pulses", 32'(pulses_w - base_w), 32'd0);
    btn_prev = 1'b1;
    cycles(2);
    btn_next = 1'b1;
    cycles(10);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    cycles(12);
    check("stagger d_state", 32'(d_state_w), 32'd0);
    check("stagger pulses", 32'(pulses_w - base_w), 32'd2);

    // 6: reset mid-debounce with the button still held
    press(1'b1, 1'b0, 10, 10);
    press(1'b1, 1'b0, 10, 10);
    check("pre-reset d_state", 32'(d_state_w), 32'd2);
    btn_next = 1'b1;
    cycles(4);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check("midreset d_state", 32'(d_state_w), 32'd0);
    check("midreset changed", 32'(changed_w), 32'd0);
    cycles(6);
    check("edge11 d_state", 32'(d_state_w), 32'd0);
    cycles(1);
    check("edge12 d_state", 32'(d_state_w), 32'd1);
    check("edge12 changed", 32'(changed_w), 32'd1);
    btn_next = 1'b0;
    cycles(10);

    // random buttons with occasional resets, checked by the model every cycle
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
      end
      btn_next = 1'($urandom_range(0, 1));
      btn_prev = 1'($urandom_range(0, 1));
      cycles($urandom_range(1, 12));
    end
    btn_next = 1'b0;
    btn_prev = 1'b0;
    cycles(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
